// File: rtl/cache_pkg.sv
// Shared types and width helpers for the parametrised direct-mapped cache.
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMP   = 2'd1,
    S_FILL  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int idx_w(input int lines);
    return clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - clog2(lines);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays for the direct-mapped cache: one combinational read
// port, one write port and a single-cycle clear of every valid bit.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LINES  = 4,
  parameter int IDX_W  = 2,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_all,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_line_tag,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [DATA_W-1:0] data_d [LINES];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clear_all) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
  end

  // Only the valid bits are reset; tag and data contents are don't-care
  // until a line is filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_line_tag = tag_q[rd_idx];
  assign rd_data     = data_q[rd_idx];
  assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

endmodule

// File: rtl/param_cache.sv
// Direct-mapped write-through cache between a CPU request port and a
// req/ack backing word memory, with flush and saturating hit/miss counters.
//
// state  | meaning
// IDLE   | waiting for cpu_req; flush clears all lines here
// CMP    | tag compare on the latched request
// FILL   | read miss: fetching the word from backing memory
// WRITE  | write-through to backing memory, update line on hit
module param_cache
  import cache_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LINES  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_hit_q, wr_hit_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              line_hit;
  logic [DATA_W-1:0] line_data;
  logic [TAG_W-1:0]  line_tag;
  logic              clear_all;
  logic              wr_en;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;

  assign req_idx = addr_q[IDX_W-1:0];
  assign req_tag = addr_q[ADDR_W-1:IDX_W];

  cache_line_store #(
    .DATA_W (DATA_W),
    .LINES  (LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .clear_all   (clear_all),
    .rd_idx      (req_idx),
    .rd_tag      (req_tag),
    .rd_hit      (line_hit),
    .rd_data     (line_data),
    .rd_line_tag (line_tag),
    .wr_en       (wr_en),
    .wr_idx      (req_idx),
    .wr_tag      (wr_tag),
    .wr_data     (wr_data)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_hit_d    = wr_hit_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    clear_all   = 1'b0;
    wr_en       = 1'b0;
    wr_tag      = req_tag;
    wr_data     = mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (flush) begin
          clear_all = 1'b1;
        end else if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = S_CMP;
        end
      end

      S_CMP: begin
        if (we_q) begin
          wr_hit_d    = line_hit;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
          state_d     = S_WRITE;
        end else if (line_hit) begin
          cpu_ready_d = 1'b1;
          cpu_rdata_d = line_data;
          if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          state_d     = S_IDLE;
        end else begin
          if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = addr_q;
          state_d     = S_FILL;
        end
      end

      S_FILL: begin
        if (mem_ack) begin
          wr_en       = 1'b1;
          wr_data     = mem_rdata;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = mem_rdata;
          mem_req_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end

      S_WRITE: begin
        // Write-hit refreshes the data only; rewriting the resident tag
        // keeps the line identity untouched. Misses do not allocate.
        if (mem_ack) begin
          wr_en       = wr_hit_q;
          wr_tag      = line_tag;
          wr_data     = wdata_q;
          cpu_ready_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_hit_q    <= 1'b0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_hit_q    <= wr_hit_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_param_cache.sv
// Bench for param_cache: directed scenarios plus random traffic checked against
// a resident-address model of a direct-mapped write-through cache.
module tb_param_cache;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance (32-bit data, 5-bit address, 4 lines)
  logic        cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0;
  logic [4:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] hit_cnt, miss_cnt;

  // small instance (16-bit data, 8-bit address, 16 lines, 2-bit counters)
  logic        b_cpu_req = 1'b0, b_cpu_we = 1'b0, b_flush = 1'b0;
  logic [7:0]  b_cpu_addr = '0;
  logic [15:0] b_cpu_wdata = '0;
  logic [15:0] b_cpu_rdata;
  logic        b_cpu_ready;
  logic        b_mem_req, b_mem_we;
  logic [7:0]  b_mem_addr;
  logic [15:0] b_mem_wdata;
  logic [15:0] b_mem_rdata = '0;
  logic        b_mem_ack = 1'b0;
  logic [1:0]  b_hit_cnt, b_miss_cnt;

  param_cache dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  param_cache #(.DATA_W(16), .ADDR_W(8), .LINES(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
    .cpu_wdata(b_cpu_wdata), .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready), .flush(b_flush),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack), .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt)
  );

  int tests = 0;
  int fails = 0;

  // environment memories and reference memories
  logic [31:0] env_mem [32];
  logic [31:0] ref_mem [32];
  logic [15:0] b_env [256];
  logic [15:0] b_ref [256];

  // reference model: which word address each line holds (-1 = empty)
  int res_a [4];
  int res_b [16];
  int exp_hits = 0, exp_misses = 0;
  int b_hits = 0, b_misses = 0;

  // responder / monitor state for the default instance
  int          lat = 3;
  logic        resp_en = 1'b1;
  int          inject_cnt = 0;
  int          served_cnt = 0;
  int          req_starts = 0;
  int          wr_count = 0;
  int          ready_seen = 0;
  int          stab_err = 0;
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Memory responder and bus monitor for the default instance.
  initial begin
    int   cnt;
    logic prev_req;
    logic [37:0] prev_bus;
    cnt = 0;
    prev_req = 1'b0;
    prev_bus = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && prev_req !== 1'b1) req_starts++;
      if (mem_req === 1'b1 && prev_req === 1'b1 && {mem_we, mem_addr, mem_wdata} !== prev_bus)
        stab_err++;
      prev_req = mem_req;
      prev_bus = {mem_we, mem_addr, mem_wdata};
      if (cpu_ready === 1'b1) ready_seen++;

      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (rst) begin
        cnt = 0;
      end else if (served_cnt != inject_cnt) begin
        mem_ack = 1'b1;
        served_cnt++;
      end else if (mem_req === 1'b1 && resp_en) begin
        if (cnt >= lat) begin
          mem_ack = 1'b1;
          cnt = 0;
          if (mem_we) begin
            env_mem[mem_addr] = mem_wdata;
            wr_count++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
          end else begin
            mem_rdata = env_mem[mem_addr];
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Zero-latency responder for the small instance.
  initial begin
    forever begin
      @(negedge clk);
      if (b_mem_ack) begin
        b_mem_ack = 1'b0;
      end else if (b_mem_req === 1'b1 && !rst) begin
        b_mem_ack = 1'b1;
        if (b_mem_we) b_env[b_mem_addr] = b_mem_wdata;
        else b_mem_rdata = b_env[b_mem_addr];
      end
    end
  end

  task automatic access(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                        input int flush_at, output logic [31:0] rd, output int lc,
                        output logic got);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wd;
    step();
    cpu_req = 1'b0;
    lc = 1;
    got = 1'b0;
    rd = '0;
    for (int i = 0; i < 200; i++) begin
      if (cpu_ready === 1'b1) begin
        got = 1'b1;
        rd = cpu_rdata;
        break;
      end
      if (lc == flush_at) flush = 1'b1;
      step();
      flush = 1'b0;
      lc++;
    end
  endtask

  task automatic do_read(input logic [4:0] addr, input int flush_at);
    logic [31:0] rd;
    int lc, starts0, idx;
    logic got, exp_hit;
    starts0 = req_starts;
    access(1'b0, addr, 32'h0, flush_at, rd, lc, got);
    idx = int'(addr) % 4;
    exp_hit = (res_a[idx] == int'(addr));
    if (exp_hit) exp_hits++;
    else begin
      exp_misses++;
      res_a[idx] = int'(addr);
    end
    chk("rd_ready", got, 1);
    chk("rd_data", rd, ref_mem[addr]);
    chk("hit_cnt", hit_cnt, exp_hits);
    chk("miss_cnt", miss_cnt, exp_misses);
    chk("rd_mem_reqs", req_starts - starts0, exp_hit ? 0 : 1);
    if (exp_hit) chk("hit_latency", lc, 2);
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    int lc, w0;
    logic got;
    w0 = wr_count;
    access(1'b1, addr, data, -1, rd, lc, got);
    ref_mem[addr] = data;
    chk("wr_ready", got, 1);
    chk("wr_mem_count", wr_count - w0, 1);
    chk("wr_mem_addr", last_waddr, addr);
    chk("wr_mem_data", last_wdata, data);
    chk("wr_hit_cnt", hit_cnt, exp_hits);
    chk("wr_miss_cnt", miss_cnt, exp_misses);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) res_a[i] = -1;
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic b_read(input logic [7:0] addr);
    logic [15:0] rd;
    logic got, exp_hit;
    int idx;
    b_cpu_req = 1'b1;
    b_cpu_addr = addr;
    step();
    b_cpu_req = 1'b0;
    got = 1'b0;
    rd = '0;
    for (int i = 0; i < 50; i++) begin
      if (b_cpu_ready === 1'b1) begin
        got = 1'b1;
        rd = b_cpu_rdata;
        break;
      end
      step();
    end
    idx = int'(addr) % 16;
    exp_hit = (res_b[idx] == int'(addr));
    if (exp_hit) b_hits++;
    else begin
      b_misses++;
      res_b[idx] = int'(addr);
    end
    chk("b_ready", got, 1);
    chk("b_data", rd, b_ref[addr]);
    chk("b_hit_cnt", b_hit_cnt, sat3(b_hits));
    chk("b_miss_cnt", b_miss_cnt, sat3(b_misses));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, s0;
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[5] = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      b_env[i] = v[15:0];
      b_ref[i] = v[15:0];
    end
    for (int i = 0; i < 4; i++) res_a[i] = -1;
    for (int i = 0; i < 16; i++) res_b[i] = -1;

    // reset values
    rst = 1'b1;
    repeat (3) step();
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    step();

    // 1: miss then hit on address 5
    do_read(5'd5, -1);
    do_read(5'd5, -1);

    // 2: write hit updates the line, write miss does not allocate
    do_write(5'd5, 32'h12345678);
    do_read(5'd5, -1);
    do_write(5'd6, 32'hA5A5_0606);
    do_read(5'd6, -1);

    // 3: conflict on index 1
    do_read(5'd9, -1);
    do_read(5'd5, -1);
    do_read(5'd9, -1);

    // 4: flush wins over a simultaneous request
    flush = 1'b1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 5'd9;
    step();
    flush = 1'b0;
    cpu_req = 1'b0;
    r0 = ready_seen;
    s0 = req_starts;
    repeat (5) step();
    chk("flush_req_ready", ready_seen - r0, 0);
    chk("flush_req_mem", req_starts - s0, 0);
    for (int i = 0; i < 4; i++) res_a[i] = -1;
    do_read(5'd9, -1);
    do_read(5'd6, -1);
    do_read(5'd5, 2);   // flush raised while FILL is in progress
    do_read(5'd5, -1);
    do_read(5'd6, -1);

    // 5: reset two cycles into FILL
    resp_en = 1'b0;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 5'd3;
    step();
    cpu_req = 1'b0;
    step();
    chk("fill_req_up", mem_req, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstfill_mem_req", mem_req, 0);
    chk("rstfill_ready", cpu_ready, 0);
    chk("rstfill_hit_cnt", hit_cnt, 0);
    chk("rstfill_miss_cnt", miss_cnt, 0);
    r0 = ready_seen;
    s0 = req_starts;
    inject_cnt++;
    repeat (5) step();
    chk("late_ack_ready", ready_seen - r0, 0);
    chk("late_ack_mem", req_starts - s0, 0);
    chk("late_ack_req", mem_req, 0);
    resp_en = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    for (int i = 0; i < 4; i++) res_a[i] = -1;
    do_read(5'd5, -1);
    do_read(5'd3, -1);

    // random traffic against the model
    for (int n = 0; n < 60; n++) begin
      int sel;
      logic [4:0] a;
      lat = $urandom_range(0, 4);
      sel = $urandom_range(0, 9);
      a = 5'($urandom_range(0, 11));
      if (sel == 0) do_flush();
      else if (sel < 4) do_write(a, $urandom);
      else do_read(a, -1);
    end
    chk("mem_bus_stable", stab_err, 0);

    // 6: small instance, zero latency, 2-bit saturating counters
    b_read(8'hFF);
    for (int i = 0; i < 5; i++) b_read(8'hFF);
    b_read(8'h0F);
    b_read(8'hFF);
    b_read(8'h0F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
